// File: rtl/vadd_sat_pipe.sv
// Two-stage SEW-partitioned vector add/sub with carry masks and saturation.
// Stage 1 forms raw byte-lane sums; stage 2 saturates and forms carry-out.
module vadd_sat_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int SEW_WIDTH  = 2,
    parameter int OP_WIDTH   = 4,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] vec0,
    input  logic [DATA_WIDTH-1:0] vec1,
    input  logic [MASK_WIDTH-1:0] cin_mask,
    input  logic [SEW_WIDTH-1:0]  sew,
    input  logic [OP_WIDTH-1:0]   op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [MASK_WIDTH-1:0] cout_mask,
    output logic                  vxsat,
    input  logic                  vxsat_clr
);

    localparam int NB = MASK_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_RSUB  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_ADC   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SBC   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SADDU = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SADD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SSUBU = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SSUB  = OP_WIDTH'(8);

    function automatic logic bit_at(input logic [DATA_WIDTH-1:0] v,
                                    input int k);
        return |((v >> k) & DATA_WIDTH'(1));
    endfunction

    logic                  v1_q, v2_q;
    logic                  adv1, adv2;
    logic [DATA_WIDTH-1:0] sum1_q, sum1_d;
    logic [NB-1:0]         cy1_q, cy1_d;
    logic [NB-1:0]         xs1_q, xs1_d;
    logic [NB-1:0]         ys1_q, ys1_d;
    logic [OP_WIDTH-1:0]   op1_q;
    logic [SEW_WIDTH-1:0]  sew1_q;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [NB-1:0]         cout_q, cout_d;
    logic                  sat_q, sat_d;
    logic                  vxsat_q;

    assign adv2      = !v2_q || out_ready;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign result    = result_q;
    assign cout_mask = cout_q;
    assign vxsat     = vxsat_q;

    // Subtraction is a + ~b + 1 - c, so borrow-in becomes an inverted carry-in.
    always_comb begin
        logic [DATA_WIDTH-1:0] x, y;
        logic sub_in, cin, cy;
        int span, e;
        sub_in = op inside {OP_SUB, OP_SBC, OP_SSUBU, OP_SSUB};
        x = vec0;
        y = vec1;
        if (op == OP_RSUB) begin
            x = vec1;
            y = ~vec0;
        end else if (sub_in) begin
            y = ~vec1;
        end
        sum1_d = '0;
        cy1_d  = '0;
        xs1_d  = '0;
        ys1_d  = '0;
        cy     = 1'b0;
        span   = 1 << sew;
        for (int i = 0; i < NB; i++) begin
            e = i >> sew;
            if ((i & (span - 1)) == 0) begin
                cin = 1'b0;
                if (op == OP_ADC)
                    cin = bit_at(DATA_WIDTH'(cin_mask), e);
                else if (op == OP_SBC)
                    cin = !bit_at(DATA_WIDTH'(cin_mask), e);
                else if (sub_in || op == OP_RSUB)
                    cin = 1'b1;
            end else begin
                cin = cy;
            end
            {cy, sum1_d[i*8 +: 8]} = {1'b0, x[i*8 +: 8]}
                                   + {1'b0, y[i*8 +: 8]} + 9'(cin);
            cy1_d[i] = cy;
            xs1_d[i] = x[i*8+7];
            ys1_d[i] = y[i*8+7];
        end
    end

    // Each byte looks up its element's top lane for carry and sign decisions.
    always_comb begin
        logic sub1, rsvd1, ovf, cyl, xsl, ysl, rsl;
        logic [7:0] satb;
        int span, l;
        sub1  = op1_q inside {OP_SUB, OP_RSUB, OP_SBC, OP_SSUBU, OP_SSUB};
        rsvd1 = op1_q > OP_SSUB;
        result_d = '0;
        cout_d   = '0;
        sat_d    = 1'b0;
        span     = 1 << sew1_q;
        for (int i = 0; i < NB; i++) begin
            l   = i | (span - 1);
            cyl = bit_at(DATA_WIDTH'(cy1_q), l);
            xsl = bit_at(DATA_WIDTH'(xs1_q), l);
            ysl = bit_at(DATA_WIDTH'(ys1_q), l);
            rsl = bit_at(sum1_q, l * 8 + 7);
            ovf = 1'b0;
            if (op1_q == OP_SADDU)
                ovf = cyl;
            else if (op1_q == OP_SSUBU)
                ovf = !cyl;
            else if (op1_q == OP_SADD || op1_q == OP_SSUB)
                ovf = (xsl == ysl) && (rsl != xsl);
            if (op1_q == OP_SADDU)
                satb = 8'hFF;
            else if (op1_q == OP_SSUBU)
                satb = 8'h00;
            else if (i == l)
                satb = xsl ? 8'h80 : 8'h7F;
            else
                satb = xsl ? 8'h00 : 8'hFF;
            if (rsvd1)
                result_d[i*8 +: 8] = 8'h00;
            else if (ovf)
                result_d[i*8 +: 8] = satb;
            else
                result_d[i*8 +: 8] = sum1_q[i*8 +: 8];
            sat_d = sat_d | ovf;
        end
        for (int j = 0; j < NB; j++) begin
            l = ((j + 1) << sew1_q) - 1;
            if (l < NB && !rsvd1) begin
                cyl = bit_at(DATA_WIDTH'(cy1_q), l);
                cout_d[j] = sub1 ? !cyl : cyl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            sum1_q   <= '0;
            cy1_q    <= '0;
            xs1_q    <= '0;
            ys1_q    <= '0;
            op1_q    <= OP_ADD;
            sew1_q   <= '0;
            result_q <= '0;
            cout_q   <= '0;
            sat_q    <= 1'b0;
            vxsat_q  <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    sum1_q <= sum1_d;
                    cy1_q  <= cy1_d;
                    xs1_q  <= xs1_d;
                    ys1_q  <= ys1_d;
                    op1_q  <= op;
                    sew1_q <= sew;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    result_q <= result_d;
                    cout_q   <= cout_d;
                    sat_q    <= sat_d;
                end
            end
            if (v2_q && out_ready && sat_q)
                vxsat_q <= 1'b1;
            else if (vxsat_clr)
                vxsat_q <= 1'b0;
        end
    end

endmodule

// File: doc/vadd_sat_pipe.md
Name: vadd_sat_pipe

Overview:
- Parametrised, pipelined successor to the single-beat SEW-partitioned vector adder in the vALU.
- Adds or subtracts DATA_WIDTH-bit vector operands split into 8/16/32/64-bit elements.
- Supports per-element carry/borrow-in (vadc/vsbc), a per-element carry-out mask (vmadc/vmsbc), and signed/unsigned saturating add/sub with a sticky vxsat flag.
- Two-stage valid/ready pipeline with backpressure; sits between the vALU operand mux and the writeback arbiter.

Parameters:
- DATA_WIDTH, 64, operand/result width; must be a multiple of 64.
- SEW_WIDTH, 2, element-width select width (0=8b, 1=16b, 2=32b, 3=64b).
- OP_WIDTH, 4, opcode width.
- MASK_WIDTH, DATA_WIDTH/8, carry-in/out mask bits (one per possible 8-bit element).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- vec0  in  DATA_WIDTH  operand a
- vec1  in  DATA_WIDTH  operand b
- cin_mask  in  MASK_WIDTH  per-element carry/borrow-in; element i uses bit i
- sew  in  SEW_WIDTH  element width
- op  in  OP_WIDTH  0 ADD, 1 SUB (a-b), 2 RSUB (b-a), 3 ADC, 4 SBC, 5 SADDU, 6 SADD, 7 SSUBU, 8 SSUB; 9-15 reserved
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- result  out  DATA_WIDTH  element results
- cout_mask  out  MASK_WIDTH  per-element carry-out (add) or borrow-out (sub); bits at index >= element count are 0
- vxsat  out  1  sticky saturation flag
- vxsat_clr  in  1  synchronous clear of vxsat

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, result=0, cout_mask=0, vxsat=0, both pipeline stages empty. Reset mid-beat discards all in-flight beats.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A beat is delivered when out_valid & out_ready.
  - Stage k advances when it is empty or its successor advances; in_ready = stage-1 empty or stage 1 advancing.
  - With out_ready held at 1, full throughput is one beat per cycle and latency is exactly 2 cycles from acceptance to out_valid.
  - With out_ready=0, result, cout_mask and out_valid hold stable; at most 2 beats are buffered, then in_ready=0.
- Element count: N = DATA_WIDTH/(8<<sew). Element j occupies bits [j*W +: W], W = 8<<sew. Carries never cross element boundaries.
- Stage 1, per element (W+1-bit arithmetic):
  - ADD/ADC/SADDU/SADD: a+b+c.
  - SUB/SBC/SSUBU/SSUB: a+~b+1-c.
  - RSUB: b+~a+1.
  - c = cin_mask[j] for ADC/SBC, otherwise 0.
  - Register the raw sum, the carry bit and the operand sign bits.
- Stage 2:
  - Non-saturating ops: result = low W bits; cout = carry for add ops and ~carry (borrow) for sub ops.
  - SADDU: overflow => all-ones.
  - SSUBU: borrow => 0.
  - SADD/SSUB: signed overflow (operand signs as the op requires, result sign differs) => 0x7F.. if a non-negative, else 0x80.. .
  - cout_mask is computed for every op.
- vxsat: set when any element of a delivered beat saturated; set is applied on the delivery cycle. vxsat_clr clears it, but a set in the same cycle wins.
- Reserved op: result=0, cout_mask=0, no vxsat effect; the handshake is unaffected.
- sew and op are captured per beat; consecutive beats may differ.

Test Plan:
- ADD sew=0, vec0=0x00000000_000000FF, vec1=0x00000000_00000001, out_ready=1 -> 2 cycles later result=0x0000000000000000, cout_mask=0x01, vxsat=0.
- SADD sew=1, element0 a=0x7FFF, b=0x0001; SSUBU sew=2 on the next cycle, element0 a=0x00000005, b=0x00000009 -> back-to-back outputs: 0x7FFF then 0x00000000; vxsat=1 after the first delivery and stays 1; vxsat_clr pulse clears it.
- ADC sew=3, a=0xFFFFFFFFFFFFFFFF, b=0, cin_mask=0x01 -> result=0, cout_mask=0x01 (bits 7:1 zero). SBC sew=3, a=0, b=0, cin_mask=0x01 -> result=0xFFFFFFFFFFFFFFFF, cout_mask=0x01.
- Backpressure: 4 beats offered each cycle with out_ready=0 -> in_ready drops after 2 beats accepted; outputs stable; releasing out_ready delivers all 4 in order with no loss or duplication.
- DATA_WIDTH=128, RSUB sew=0, all a bytes=0x03, all b bytes=0x01 -> every byte of result=0xFE, cout_mask=0xFFFF.
- Assert rst low while 2 beats are in flight -> out_valid=0, result=0, vxsat=0 immediately; after release, the first new beat completes in 2 cycles.
